// File: rtl/shift_seq_ctrl.sv
// Counter-driven shift sequencer: accepts SHIFT/LOAD/CLEAR commands and performs
// N single-position shifts of a (WIDTH+1)-bit register, then reports a done pulse.
module shift_seq_ctrl #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_op,
    input  logic [CNT_W-1:0] cmd_cnt,
    input  logic             cmd_sin,
    input  logic [WIDTH:0]   load_data,
    input  logic             abort,
    output logic [WIDTH:0]   q,
    output logic             busy,
    output logic [CNT_W-1:0] cnt_left,
    output logic             done,
    output logic [1:0]       done_status
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    localparam logic [1:0] OP_SHIFT = 2'b00;
    localparam logic [1:0] OP_LOAD  = 2'b01;
    localparam logic [1:0] OP_CLEAR = 2'b10;

    localparam logic [1:0] STS_OK      = 2'b00;
    localparam logic [1:0] STS_ABORTED = 2'b01;
    localparam logic [1:0] STS_ILLEGAL = 2'b10;

    state_t           state_q, state_d;
    logic [WIDTH:0]   q_q, q_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             sin_q, sin_d;
    logic [1:0]       status_q, status_d;

    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned (no latches).
        state_d  = state_q;
        q_d      = q_q;
        cnt_d    = cnt_q;
        sin_d    = sin_q;
        status_d = STS_OK;

        case (state_q)
            ST_IDLE: begin
                if (cmd_valid) begin
                    state_d = ST_DONE;
                    case (cmd_op)
                        OP_SHIFT: begin
                            if (cmd_cnt != '0) begin
                                state_d = ST_SHIFT;
                                sin_d   = cmd_sin;
                                cnt_d   = cmd_cnt;
                            end
                        end
                        OP_LOAD:  q_d = load_data;
                        OP_CLEAR: q_d = '0;
                        default:  status_d = STS_ILLEGAL;
                    endcase
                end
            end

            ST_SHIFT: begin
                // Abort takes priority over the shift, including the final one.
                if (abort) begin
                    state_d  = ST_DONE;
                    cnt_d    = '0;
                    status_d = STS_ABORTED;
                end else begin
                    q_d = {q_q[WIDTH-1:0], sin_q};
                    if (cnt_q <= CNT_W'(1)) begin
                        state_d = ST_DONE;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end
                end
            end

            default: state_d = ST_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            q_q      <= '0;
            cnt_q    <= '0;
            sin_q    <= 1'b0;
            status_q <= STS_OK;
        end else begin
            state_q  <= state_d;
            q_q      <= q_d;
            cnt_q    <= cnt_d;
            sin_q    <= sin_d;
            status_q <= status_d;
        end
    end

    assign cmd_ready   = (state_q == ST_IDLE);
    assign busy        = (state_q == ST_SHIFT);
    assign done        = (state_q == ST_DONE);
    assign done_status = status_q;
    assign q           = q_q;
    assign cnt_left    = cnt_q;

endmodule

// File: tb/tb_shift_seq_ctrl.sv
// Directed bench for shift_seq_ctrl: inputs change on the falling edge, outputs
// are compared on the falling edge after each rising edge.
module tb_shift_seq_ctrl;

    localparam int WIDTH = 8;
    localparam int CNT_W = 3;

    logic             clk;
    logic             rst_n;
    logic             cmd_valid;
    logic             cmd_ready;
    logic [1:0]       cmd_op;
    logic [CNT_W-1:0] cmd_cnt;
    logic             cmd_sin;
    logic [WIDTH:0]   load_data;
    logic             abort;
    logic [WIDTH:0]   q;
    logic             busy;
    logic [CNT_W-1:0] cnt_left;
    logic             done;
    logic [1:0]       done_status;

    int total = 0;
    int bad   = 0;

    shift_seq_ctrl #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_op     (cmd_op),
        .cmd_cnt    (cmd_cnt),
        .cmd_sin    (cmd_sin),
        .load_data  (load_data),
        .abort      (abort),
        .q          (q),
        .busy       (busy),
        .cnt_left   (cnt_left),
        .done       (done),
        .done_status(done_status)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_load(input logic [WIDTH:0] data);
        cmd_valid = 1'b1;
        cmd_op    = 2'b01;
        load_data = data;
        step();
        cmd_valid = 1'b0;
        check("load_q", 16'(q), 16'(data));
        step();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n     = 1'b0;
        cmd_valid = 1'b0;
        cmd_op    = 2'b00;
        cmd_cnt   = '0;
        cmd_sin   = 1'b0;
        load_data = '0;
        abort     = 1'b0;

        #12;
        check("rst_q",     16'(q), 16'h000);
        check("rst_ready", 16'(cmd_ready), 16'd1);
        check("rst_busy",  16'(busy), 16'd0);
        check("rst_cnt",   16'(cnt_left), 16'd0);
        check("rst_done",  16'(done), 16'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // LOAD 0A5 with one-cycle done pulse
        cmd_valid = 1'b1; cmd_op = 2'b01; load_data = 9'h0A5;
        check("t1_ready", 16'(cmd_ready), 16'd1);
        step();
        cmd_valid = 1'b0; load_data = 9'h1FF;
        check("t1_q",      16'(q), 16'h0A5);
        check("t1_done",   16'(done), 16'd1);
        check("t1_status", 16'(done_status), 16'd0);
        check("t1_ready0", 16'(cmd_ready), 16'd0);
        step();
        check("t1_done_off", 16'(done), 16'd0);
        check("t1_ready1",   16'(cmd_ready), 16'd1);
        check("t1_q_hold",   16'(q), 16'h0A5);

        // SHIFT 3 with sin=1 from 001; cmd_sin changes mid-shift must not matter
        do_load(9'h001);
        cmd_valid = 1'b1; cmd_op = 2'b00; cmd_cnt = 3'd3; cmd_sin = 1'b1;
        step();
        cmd_valid = 1'b0; cmd_sin = 1'b0; cmd_cnt = 3'd6;
        check("t2_busy0", 16'(busy), 16'd1);
        check("t2_cnt0",  16'(cnt_left), 16'd3);
        check("t2_q0",    16'(q), 16'h001);
        step();
        check("t2_cnt1", 16'(cnt_left), 16'd2);
        check("t2_q1",   16'(q), 16'h003);
        step();
        check("t2_cnt2", 16'(cnt_left), 16'd1);
        check("t2_q2",   16'(q), 16'h007);
        check("t2_busy2", 16'(busy), 16'd1);
        step();
        check("t2_q3",     16'(q), 16'h00F);
        check("t2_done",   16'(done), 16'd1);
        check("t2_status", 16'(done_status), 16'd0);
        check("t2_busy3",  16'(busy), 16'd0);
        check("t2_cnt3",   16'(cnt_left), 16'd0);
        step();
        check("t2_idle", 16'(cmd_ready), 16'd1);

        // SHIFT 7 sin=0 from 1FF, abort at the third shift edge
        do_load(9'h1FF);
        cmd_valid = 1'b1; cmd_op = 2'b00; cmd_cnt = 3'd7; cmd_sin = 1'b0;
        step();
        cmd_valid = 1'b0;
        check("t3_cnt0", 16'(cnt_left), 16'd7);
        step();
        check("t3_q1", 16'(q), 16'h1FE);
        step();
        check("t3_q2", 16'(q), 16'h1FC);
        check("t3_cnt2", 16'(cnt_left), 16'd5);
        abort = 1'b1;
        step();
        abort = 1'b0;
        check("t3_q_ab",    16'(q), 16'h1FC);
        check("t3_done",    16'(done), 16'd1);
        check("t3_status",  16'(done_status), 16'd1);
        check("t3_cnt_ab",  16'(cnt_left), 16'd0);
        // abort while in DONE has no effect on the return to IDLE
        abort = 1'b1;
        step();
        abort = 1'b0;
        check("t3_idle",   16'(cmd_ready), 16'd1);
        check("t3_status_clr", 16'(done_status), 16'd0);

        // SHIFT 0 then reserved op with cmd_valid held high
        cmd_valid = 1'b1; cmd_op = 2'b00; cmd_cnt = 3'd0;
        step();
        cmd_op = 2'b11;
        check("t4_done_a",   16'(done), 16'd1);
        check("t4_status_a", 16'(done_status), 16'd0);
        check("t4_q_a",      16'(q), 16'h1FC);
        step();
        check("t4_gap_done",  16'(done), 16'd0);
        check("t4_gap_ready", 16'(cmd_ready), 16'd1);
        step();
        cmd_valid = 1'b0;
        check("t4_done_b",   16'(done), 16'd1);
        check("t4_status_b", 16'(done_status), 16'd2);
        check("t4_q_b",      16'(q), 16'h1FC);
        step();
        check("t4_idle", 16'(done), 16'd0);

        // Abort coinciding with the final shift: abort wins
        do_load(9'h001);
        cmd_valid = 1'b1; cmd_op = 2'b00; cmd_cnt = 3'd1; cmd_sin = 1'b1;
        step();
        cmd_valid = 1'b0;
        abort = 1'b1;
        step();
        abort = 1'b0;
        check("t5_q",      16'(q), 16'h001);
        check("t5_status", 16'(done_status), 16'd1);
        step();

        // Async reset mid-SHIFT with cnt_left=4
        do_load(9'h0A5);
        cmd_valid = 1'b1; cmd_op = 2'b00; cmd_cnt = 3'd7; cmd_sin = 1'b1;
        step();
        cmd_valid = 1'b0;
        step();
        step();
        step();
        check("t6_q_pre",   16'(q), 16'h12F);
        check("t6_cnt_pre", 16'(cnt_left), 16'd4);
        #2;
        rst_n = 1'b0;
        #1;
        check("t6_q_rst",    16'(q), 16'h000);
        check("t6_busy_rst", 16'(busy), 16'd0);
        check("t6_cnt_rst",  16'(cnt_left), 16'd0);
        check("t6_done_rst", 16'(done), 16'd0);
        @(negedge clk);
        rst_n = 1'b1;
        step();
        check("t6_ready",   16'(cmd_ready), 16'd1);
        check("t6_no_done", 16'(done), 16'd0);

        // CLEAR with cmd_valid held: second accept at E0+2
        do_load(9'h0A5);
        cmd_valid = 1'b1; cmd_op = 2'b10;
        step();
        check("t7_q",     16'(q), 16'h000);
        check("t7_done0", 16'(done), 16'd1);
        step();
        check("t7_done1", 16'(done), 16'd0);
        check("t7_ready", 16'(cmd_ready), 16'd1);
        step();
        cmd_valid = 1'b0;
        check("t7_done2", 16'(done), 16'd1);
        check("t7_stat2", 16'(done_status), 16'd0);
        step();
        check("t7_done3", 16'(done), 16'd0);
        step();
        check("t7_done4", 16'(done), 16'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/shift_seq_ctrl.md
Name: shift_seq_ctrl

Overview:
Sequencing controller for the (WIDTH+1)-bit shift register datapath. It replaces a variable-count loop with a counter-driven FSM that performs exactly N single-position shifts over N clock cycles. Commands arrive on a valid/ready interface. Completion is reported with a one-cycle done pulse and a status code. The block owns the register and drives it as output q.

Parameters:
WIDTH, 8, q is WIDTH+1 bits wide (bits WIDTH..0)
CNT_W, 3, width of the shift-count field; max count 2**CNT_W-1

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
cmd_valid  input  1  command present
cmd_ready  output  1  controller can accept a command (high only in IDLE)
cmd_op  input  2  00 SHIFT, 01 LOAD, 10 CLEAR, 11 reserved
cmd_cnt  input  CNT_W  shift count for SHIFT; ignored otherwise
cmd_sin  input  1  serial-in bit for SHIFT, captured at accept
load_data  input  WIDTH+1  value for LOAD, sampled at accept
abort  input  1  terminate an in-progress SHIFT
q  output  WIDTH+1  shift register contents
busy  output  1  high in SHIFT state
cnt_left  output  CNT_W  shifts remaining; 0 outside SHIFT
done  output  1  one-cycle completion pulse
done_status  output  2  valid when done=1: 00 ok, 01 aborted, 10 illegal op; 00 otherwise

Behaviour:
- Reset (rst_n low, asynchronous): state=IDLE, q=0, cnt_left=0, sin register=0, done=0, done_status=00. cmd_ready=1 because state is IDLE.
- States: IDLE, SHIFT, DONE. cmd_ready = (state==IDLE). busy = (state==SHIFT). done = (state==DONE).
- Accept: a command is accepted at a rising edge when cmd_valid && cmd_ready. Accept edge = E0.
- LOAD: q<=load_data at E0. Next state DONE with status 00.
- CLEAR: q<=0 at E0. Next state DONE with status 00.
- SHIFT, cmd_cnt=0: q unchanged. Next state DONE with status 00.
- SHIFT, cmd_cnt=N>0: at E0 capture sin<=cmd_sin and cnt_left<=N, then go to SHIFT.
  - In SHIFT, at each edge with abort=0: q<={q[WIDTH-1:0], sin} and cnt_left decrements.
  - When cnt_left==1 at an edge, that edge performs the last shift and moves to DONE.
  - Shifts therefore occur on edges E1..EN. done is high in the cycle after EN. Back in IDLE after edge EN+1.
- Reserved op 11: q unchanged. Next state DONE with status 10.
- DONE: lasts exactly one cycle, then IDLE. A command cannot be accepted in DONE. Minimum accept-to-accept spacing is 2 cycles for non-shift ops and N+2 for SHIFT N.
- Abort:
  - Sampled only in SHIFT. abort=1 at an edge suppresses that edge's shift and moves to DONE with status 01.
  - q holds the shifts already completed; cnt_left clears to 0.
  - abort in IDLE or DONE has no effect.
  - abort and the final shift at the same edge: abort wins. q does not take the final shift; status 01.
- cmd_sin, cmd_cnt and load_data are don't-care except at the accept edge. Changes during SHIFT have no effect.
- cmd_valid held high through DONE: the command is accepted at the first edge after returning to IDLE. No command is lost or duplicated.
- Reset mid-SHIFT: immediate return to reset values. No done pulse is produced.
- Bits shifted out of q[WIDTH] are discarded. cnt_left never underflows.

Test Plan:
- Reset then LOAD 9'h0A5 -> cmd_ready=1 after reset; q=9'h0A5 after E0; done=1 with status 00 for exactly one cycle; cmd_ready=0 during DONE.
- SHIFT cnt=3 sin=1 from q=9'h001 -> busy for 3 cycles; cnt_left 3,2,1; q=9'h003, 9'h007, 9'h00F; done with status 00 in the cycle after the third shift.
- SHIFT cnt=7 sin=0 from q=9'h1FF, abort asserted at the 3rd SHIFT edge -> q=9'h1FC (two shifts only); done with status 01; cnt_left=0.
- SHIFT cnt=0 and op=11 back-to-back with cmd_valid held high -> first gives done/00 with q unchanged; second is accepted the cycle after DONE and gives done/10 with q unchanged.
- Async reset: drop rst_n mid-SHIFT with cnt_left=4 -> q=0, busy=0, cnt_left=0 immediately without waiting for a clock edge; no done pulse; cmd_ready=1 after release.
- CLEAR with cmd_valid held: q=0; exactly one done pulse per accepted command; the second accept is at edge E0+2.
